// File: rtl/contador_bcd.sv
// contador_bcd: prescaled up/down BCD digit (0-9) with preload, carry/borrow pulse and a pushbutton pause.
// Define CONTADOR_DEBOUNCE_EN to build the button debouncer; without it DB_CYCLES is ignored.
module contador_bcd #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] dato,
    input  logic       btn_pausa,
    output logic [3:0] A,
    output logic       tick,
    output logic       acarreo,
    output logic       pausado
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [0:0] {
        CORRIENDO = 1'b0,
        PAUSADO   = 1'b1
    } pausa_t;

    function automatic logic [3:0] sat_bcd(input logic [3:0] v);
        logic [3:0] r;
        if (v > 4'd9) begin
            r = 4'd9;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic          sync1_r;
    logic          sync2_r;
    logic          btn_level_s;
    logic          level_d_r;
    logic          rise_s;
    pausa_t        state_r;
    pausa_t        state_next_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_next_s;
    logic [3:0]    a_next_s;
    logic          step_s;
    logic          wrap_s;

    // two-flop synchronizer for the raw pushbutton
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_pausa;
            sync2_r <= sync1_r;
        end
    end

`ifdef CONTADOR_DEBOUNCE_EN
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic [DBW-1:0] db_cnt_r;
    logic           db_level_r;

    // accept a new level after DB_CYCLES consecutive differing samples; any return restarts the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r   <= {DBW{1'b0}};
            db_level_r <= 1'b0;
        end else if (sync2_r == db_level_r) begin
            db_cnt_r   <= {DBW{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
            db_cnt_r   <= {DBW{1'b0}};
            db_level_r <= sync2_r;
        end else begin
            db_cnt_r   <= db_cnt_r + 1'b1;
        end
    end

    assign btn_level_s = db_level_r;
`else
    logic unused_db_cycles_s;
    assign unused_db_cycles_s = (DB_CYCLES > 0);
    assign btn_level_s        = sync2_r;
`endif

    assign rise_s  = btn_level_s & ~level_d_r;
    assign pausado = (state_r == PAUSADO);

    // pause state and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
            state_r   <= CORRIENDO;
        end else begin
            level_d_r <= btn_level_s;
            state_r   <= state_next_s;
        end
    end

    // each accepted press flips between running and paused
    always_comb begin
        state_next_s = state_r;
        if (rise_s) begin
            case (state_r)
                CORRIENDO: state_next_s = PAUSADO;
                PAUSADO:   state_next_s = CORRIENDO;
                default:   state_next_s = CORRIENDO;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // prescaler advance, step detection and next digit; the step sees the pre-toggle pause state
    always_comb begin
        presc_next_s = presc_r;
        a_next_s     = A;
        step_s       = 1'b0;
        wrap_s       = 1'b0;
        if (load) begin
            presc_next_s = {PW{1'b0}};
            a_next_s     = sat_bcd(dato);
        end else if (en && (state_r == CORRIENDO)) begin
            if (presc_r == PRESC_LAST) begin
                presc_next_s = {PW{1'b0}};
                step_s       = 1'b1;
                if (dir) begin
                    if (A >= 4'd9) begin
                        a_next_s = 4'd0;
                        wrap_s   = 1'b1;
                    end else begin
                        a_next_s = A + 4'd1;
                    end
                end else begin
                    if (A == 4'd0) begin
                        a_next_s = 4'd9;
                        wrap_s   = 1'b1;
                    end else if (A > 4'd9) begin
                        a_next_s = 4'd9;
                    end else begin
                        a_next_s = A - 4'd1;
                    end
                end
            end else begin
                presc_next_s = presc_r + 1'b1;
            end
        end else begin
            presc_next_s = presc_r;
        end
    end

    // registered digit, pulses and prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
            A       <= 4'd0;
            tick    <= 1'b0;
            acarreo <= 1'b0;
        end else begin
            presc_r <= presc_next_s;
            A       <= a_next_s;
            tick    <= step_s;
            acarreo <= wrap_s;
        end
    end

endmodule

// File: tb/tb_contador_bcd.sv
// Self-checking bench for contador_bcd (DIV=10, DB_CYCLES=4); works with or without CONTADOR_DEBOUNCE_EN.
module tb_contador_bcd;
    localparam int DIV = 10;
    localparam int DBC = 4;
`ifdef CONTADOR_DEBOUNCE_EN
    localparam int LAT       = DBC + 3;
    localparam bit DEBOUNCED = 1'b1;
`else
    localparam int LAT       = 3;
    localparam bit DEBOUNCED = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       en        = 1'b0;
    logic       dir       = 1'b1;
    logic       load      = 1'b0;
    logic [3:0] dato      = 4'd0;
    logic       btn_pausa = 1'b0;
    logic [3:0] A;
    logic       tick;
    logic       acarreo;
    logic       pausado;

    contador_bcd #(.CLK_HZ(10), .TICK_HZ(1), .DB_CYCLES(DBC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .dato(dato),
        .btn_pausa(btn_pausa), .A(A), .tick(tick), .acarreo(acarreo), .pausado(pausado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dato;
        int         exp_a;
    } load_vec_t;

    load_vec_t lv [8];
    bit        bp [8];

    int n_checks = 0;
    int n_pass   = 0;
    int ncyc     = 0;
    int m_a, m_ph;
    bit m_tick, m_carry, m_paused;
    int toggles [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    endtask

    task automatic model_reset();
        m_a = 0; m_ph = 0; m_tick = 1'b0; m_carry = 1'b0; m_paused = 1'b0;
        toggles.delete();
    endtask

    // Advance the reference model by one edge using the current inputs, clock, then compare.
    task automatic cyc();
        int e;
        e = ncyc + 1;
        m_tick = 1'b0;
        m_carry = 1'b0;
        if (load) begin
            m_a  = (int'(dato) > 9) ? 9 : int'(dato);
            m_ph = 0;
        end else if (en && !m_paused) begin
            if (m_ph == DIV - 1) begin
                m_ph   = 0;
                m_tick = 1'b1;
                if (dir) begin
                    m_carry = (m_a == 9);
                    m_a = (m_a + 1) % 10;
                end else begin
                    m_carry = (m_a == 0);
                    m_a = (m_a + 9) % 10;
                end
            end else begin
                m_ph = m_ph + 1;
            end
        end
        while (toggles.size() > 0 && toggles[0] == e) begin
            m_paused = !m_paused;
            void'(toggles.pop_front());
        end
        @(posedge clk);
        ncyc = e;
        #1;
        chk("A", int'(A), m_a);
        chk("tick", int'(tick), int'(m_tick));
        chk("acarreo", int'(acarreo), int'(m_carry));
        chk("pausado", int'(pausado), int'(m_paused));
        chk("A_in_range", int'(A <= 4'd9), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected earlier end", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit prev_raw, raw, prev_p;
        int rises, last_rise, nchg;

        lv[0] = '{4'd0,  0};
        lv[1] = '{4'd3,  3};
        lv[2] = '{4'd9,  9};
        lv[3] = '{4'd10, 9};
        lv[4] = '{4'd12, 9};
        lv[5] = '{4'd15, 9};
        lv[6] = '{4'd7,  7};
        lv[7] = '{4'd11, 9};
        bp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // reset held with en=1
        model_reset();
        rst_n = 1'b0; en = 1'b1; dir = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_A", int'(A), 0);
            chk("rst_tick", int'(tick), 0);
            chk("rst_acarreo", int'(acarreo), 0);
            chk("rst_pausado", int'(pausado), 0);
        end
        rst_n = 1'b1;

        // free run up: tick every DIV clocks, wrap 9->0 with carry
        for (int i = 1; i <= 100; i++) begin
            cyc();
            chk("run_tick", int'(tick), int'(i % 10 == 0));
            chk("run_A", int'(A), (i / 10) % 10);
            chk("run_carry", int'(acarreo), int'(i == 100));
        end

        // down wrap from a preload of 2
        dir = 1'b0; load = 1'b1; dato = 4'd2;
        cyc();
        load = 1'b0;
        chk("dn_load_A", int'(A), 2);
        for (int i = 1; i <= 30; i++) begin
            cyc();
            chk("dn_A", int'(A), (i < 10) ? 2 : (i < 20) ? 1 : (i < 30) ? 0 : 9);
            chk("dn_carry", int'(acarreo), int'(i == 30));
        end

        // preload table with saturation, both en values
        dir = 1'b1;
        for (int k = 0; k < 8; k++) begin
            dato = lv[k].dato; load = 1'b1; en = (k % 2 == 0);
            cyc();
            chk("ld_A", int'(A), lv[k].exp_a);
            chk("ld_tick", int'(tick), 0);
        end
        load = 1'b0; en = 1'b1;

        // load coincident with a due wrap step: no tick/carry, next step DIV later
        load = 1'b1; dato = 4'd9; cyc(); load = 1'b0;
        repeat (DIV - 1) cyc();
        load = 1'b1; dato = 4'd3; cyc(); load = 1'b0;
        chk("ldstep_A", int'(A), 3);
        chk("ldstep_tick", int'(tick), 0);
        chk("ldstep_carry", int'(acarreo), 0);
        for (int i = 1; i <= DIV; i++) begin
            cyc();
            chk("ldstep_next", int'(tick), int'(i == DIV));
        end
        chk("ldstep_A2", int'(A), 4);

        // pause mid-interval, hold, resume with preserved phase
        load = 1'b1; dato = 4'd0; cyc(); load = 1'b0;
        btn_pausa = 1'b1; toggles.push_back(ncyc + LAT);
        for (int i = 1; i <= LAT; i++) begin
            cyc();
            chk("pause_lat", int'(pausado), int'(i == LAT));
        end
        btn_pausa = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("frozen_A", int'(A), 0);
            chk("frozen_tick", int'(tick), 0);
        end
        btn_pausa = 1'b1; toggles.push_back(ncyc + LAT);
        for (int i = 1; i <= LAT; i++) begin
            cyc();
            chk("resume_lat", int'(pausado), int'(i != LAT));
        end
        btn_pausa = 1'b0;
        for (int i = 1; i <= DIV - LAT; i++) begin
            cyc();
            chk("resume_tick", int'(tick), int'(i == DIV - LAT));
        end
        chk("resume_A", int'(A), 1);
        repeat (10) cyc();

        // bouncing press: 1,0,1,0 at 2-clock spacing then held high
        prev_raw = 1'b0; rises = 0; last_rise = 0; nchg = 0; prev_p = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            raw = (k < 8) ? bp[k] : 1'b1;
            if (raw && !prev_raw) begin
                rises++;
                last_rise = ncyc;
                if (!DEBOUNCED) toggles.push_back(ncyc + LAT);
            end
            btn_pausa = raw;
            prev_raw = raw;
            if (k < 8) begin
                cyc();
                if (pausado != prev_p) nchg++;
                prev_p = pausado;
            end
        end
        if (DEBOUNCED) toggles.push_back(last_rise + LAT);
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (pausado != prev_p) nchg++;
            prev_p = pausado;
        end
        chk("bounce_toggles", nchg, DEBOUNCED ? 1 : rises);
        btn_pausa = 1'b0;
        repeat (10) cyc();

        // asynchronous reset in the middle of a count and of a pending press
        load = 1'b1; dato = 4'd5; cyc(); load = 1'b0;
        btn_pausa = 1'b1; toggles.push_back(ncyc + LAT);
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_A", int'(A), 0);
        chk("arst_tick", int'(tick), 0);
        chk("arst_pausado", int'(pausado), 0);
        btn_pausa = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (LAT + 12) cyc();

        // randomized en/dir/load/dato against the reference model
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 7) != 0);
            dir  = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 11) == 0);
            dato = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
